fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 61 ++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID pipeline register, honouring stall and redirect requests.
module fetch_stage #(
    parameter int unsigned      DBITS               = 32,
    parameter int unsigned      INST_BIT_WIDTH      = 32,
    parameter logic [DBITS-1:0] INST_SIZE           = 32'd4,
    parameter logic [DBITS-1:0] START_PC            = 32'h40,
    parameter int unsigned      IMEM_ADDR_BIT_WIDTH = 11,
    parameter logic [INST_BIT_WIDTH-1:0] BUBBLE_INST = 32'h00000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           redirectEn,
    input  logic [DBITS-1:0]               redirectPc,
    output logic [IMEM_ADDR_BIT_WIDTH-1:0] imemAddr,
    input  logic [INST_BIT_WIDTH-1:0]      imemData,
    output logic [DBITS-1:0]               pc,
    output logic [INST_BIT_WIDTH-1:0]      ifInst,
    output logic [DBITS-1:0]               ifPc,
    output logic [DBITS-1:0]               ifPcPlus4,
    output logic                           ifValid,
    output logic                           misalignErr,
    output logic [31:0]                    fetchCount
);

    logic [DBITS-1:0] pc_next_seq;

    assign pc_next_seq = pc + INST_SIZE;
    assign imemAddr    = pc[IMEM_ADDR_BIT_WIDTH+1:2];

    // Redirect outranks stall so a taken branch is never lost behind a hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= START_PC;
            ifInst      <= BUBBLE_INST;
            ifPc        <= '0;
            ifPcPlus4   <= '0;
            ifValid     <= 1'b0;
            misalignErr <= 1'b0;
            fetchCount  <= '0;
        end else if (redirectEn) begin
            pc        <= {redirectPc[DBITS-1:2], 2'b00};
            ifInst    <= BUBBLE_INST;
            ifPc      <= '0;
            ifPcPlus4 <= '0;
            ifValid   <= 1'b0;
            if (redirectPc[1:0] != 2'b00) begin
                misalignErr <= 1'b1;
            end
        end else if (!stall) begin
            pc         <= pc_next_seq;
            ifInst     <= imemData;
            ifPc       <= pc;
            ifPcPlus4  <= pc_next_seq;
            ifValid    <= 1'b1;
            fetchCount <= fetchCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push expected IF state,
// a negedge monitor pops and compares against the DUT.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirectEn;
    logic [31:0] redirectPc;
    logic [10:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] ifInst;
    logic [31:0] ifPc;
    logic [31:0] ifPcPlus4;
    logic        ifValid;
    logic        misalignErr;
    logic [31:0] fetchCount;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ifpc;
        logic [31:0] p4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirectEn (redirectEn),
        .redirectPc (redirectPc),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .pc         (pc),
        .ifInst     (ifInst),
        .ifPc       (ifPc),
        .ifPcPlus4  (ifPcPlus4),
        .ifValid    (ifValid),
        .misalignErr(misalignErr),
        .fetchCount (fetchCount)
    );

    // Instruction memory model: word at address a holds 0xA0 + a.
    assign imemData = 32'hA0 + {21'd0, imemAddr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] ip, input logic [31:0] p4,
                                input logic v, input logic m, input logic [31:0] c);
        exp_t e;
        e.pc = p; e.inst = i; e.ifpc = ip; e.p4 = p4;
        e.valid = v; e.mis = m; e.cnt = c;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] exp_addr;
        exp_addr = {21'd0, e.pc[12:2]};
        cmp("pc", pc, e.pc);
        cmp("imemAddr", {21'd0, imemAddr}, exp_addr);
        cmp("ifInst", ifInst, e.inst);
        cmp("ifPc", ifPc, e.ifpc);
        cmp("ifPcPlus4", ifPcPlus4, e.p4);
        cmp("ifValid", {31'd0, ifValid}, {31'd0, e.valid});
        cmp("misalignErr", {31'd0, misalignErr}, {31'd0, e.mis});
        cmp("fetchCount", fetchCount, e.cnt);
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic ren,
                                 input logic [31:0] rpc, input exp_t e);
        reset      = rst;
        stall      = stl;
        redirectEn = ren;
        redirectPc = rpc;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        exp_t rst_e;
        rst_e = mk(32'h40, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1; stall = 1'b0; redirectEn = 1'b0; redirectPc = '0;

        applyStimulus(1, 0, 0, 0, rst_e);
        applyStimulus(1, 0, 0, 0, rst_e);
        // free running from START_PC
        applyStimulus(0, 0, 0, 0, mk(32'h44, 32'hB0, 32'h40, 32'h44, 1, 0, 1));
        applyStimulus(0, 0, 0, 0, mk(32'h48, 32'hB1, 32'h44, 32'h48, 1, 0, 2));
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 0, mk(32'h48, 32'hB1, 32'h44, 32'h48, 1, 0, 2));
        applyStimulus(0, 0, 0, 0, mk(32'h4C, 32'hB2, 32'h48, 32'h4C, 1, 0, 3));
        applyStimulus(0, 0, 0, 0, mk(32'h50, 32'hB3, 32'h4C, 32'h50, 1, 0, 4));
        // redirect, then first target instruction
        applyStimulus(0, 0, 1, 32'h100, mk(32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 4));
        applyStimulus(0, 0, 0, 0, mk(32'h104, 32'hE0, 32'h100, 32'h104, 1, 0, 5));
        // redirect together with stall
        applyStimulus(0, 1, 1, 32'h200, mk(32'h200, 32'h0, 32'h0, 32'h0, 0, 0, 5));
        applyStimulus(0, 1, 0, 0, mk(32'h200, 32'h0, 32'h0, 32'h0, 0, 0, 5));
        applyStimulus(0, 0, 0, 0, mk(32'h204, 32'h120, 32'h200, 32'h204, 1, 0, 6));
        // back-to-back redirects
        applyStimulus(0, 0, 1, 32'h300, mk(32'h300, 32'h0, 32'h0, 32'h0, 0, 0, 6));
        applyStimulus(0, 0, 1, 32'h400, mk(32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 6));
        applyStimulus(0, 0, 0, 0, mk(32'h404, 32'h1A0, 32'h400, 32'h404, 1, 0, 7));
        // misaligned target: sticky error
        applyStimulus(0, 0, 1, 32'h203, mk(32'h200, 32'h0, 32'h0, 32'h0, 0, 1, 7));
        for (int k = 1; k <= 10; k++)
            applyStimulus(0, 0, 0, 0, mk(32'h200 + 4 * k, 32'h120 + k - 1,
                                         32'h200 + 4 * (k - 1), 32'h200 + 4 * k,
                                         1, 1, 7 + k));
        applyStimulus(1, 0, 0, 0, rst_e);
        applyStimulus(0, 0, 0, 0, mk(32'h44, 32'hB0, 32'h40, 32'h44, 1, 0, 1));
        // PC wrap at top of address space
        applyStimulus(0, 0, 1, 32'hFFFFFFFC, mk(32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 0, 0, 1));
        applyStimulus(0, 0, 0, 0, mk(32'h0, 32'h89F, 32'hFFFFFFFC, 32'h0, 1, 0, 2));
        applyStimulus(0, 0, 0, 0, mk(32'h4, 32'hA0, 32'h0, 32'h4, 1, 0, 3));
        // reset during stall and during redirect
        applyStimulus(0, 1, 0, 0, mk(32'h4, 32'hA0, 32'h0, 32'h4, 1, 0, 3));
        applyStimulus(1, 1, 0, 0, rst_e);
        applyStimulus(1, 0, 1, 32'h500, rst_e);
        applyStimulus(0, 0, 0, 0, mk(32'h44, 32'hB0, 32'h40, 32'h44, 1, 0, 1));

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
